// File: rtl/fem_cmd_pkg.sv
// Shared constants, frame layout and state encoding for the FEM serial command deserializer.
// Frame on the line, MSB first: SYNC[7:0], CMD[4:0], P, STOP[1:0].
package fem_cmd_pkg;

    localparam int SYNC_W    = 8;
    localparam int CMD_W     = 5;
    localparam int PAR_W     = 1;
    localparam int STOP_W    = 2;
    localparam int PAYLOAD_W = CMD_W + PAR_W + STOP_W;
    localparam int FRAME_LEN = SYNC_W + PAYLOAD_W;
    localparam int BIT_CNT_W = $clog2(PAYLOAD_W);

    localparam int RUN_W = 4;
    localparam int ERR_W = 8;

    localparam logic [SYNC_W-1:0] DEF_SYNC_WORD = 8'hB8;

    localparam int CMD_L1A       = 4;
    localparam int CMD_L1A_MATCH = 3;
    localparam int CMD_RESYNC    = 2;
    localparam int CMD_INJPLS    = 1;
    localparam int CMD_EXTPLS    = 0;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        EVAL    = 2'd2
    } deser_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic              par;
        logic [STOP_W-1:0] stop;
    } payload_t;

    // Even parity over CMD+P, zero stop bits, and L1A_MATCH only alongside L1A.
    function automatic logic frame_good(input payload_t pl);
        logic par_ok;
        logic stop_ok;
        logic cmd_ok;
        par_ok  = ~(^{pl.cmd, pl.par});
        stop_ok = (pl.stop == '0);
        cmd_ok  = !(pl.cmd[CMD_L1A_MATCH] && !pl.cmd[CMD_L1A]);
        return par_ok && stop_ok && cmd_ok;
    endfunction

endpackage

// File: rtl/fem_lock_mon.sv
// Link lock monitor: consecutive good/bad frame runs, LOCKED flag and saturating error count.
// Updates on the edge that closes an EVAL cycle; no backpressure, one verdict per cycle at most.
module fem_lock_mon
    import fem_cmd_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             eval_vld,
    input  logic             eval_good,
    input  logic             link_loss,
    input  logic             clr_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] LOCK_TH   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_TH = RUN_W'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    logic [RUN_W-1:0] good_run;
    logic [RUN_W-1:0] bad_run;
    logic [RUN_W-1:0] good_inc;
    logic [RUN_W-1:0] bad_inc;
    logic [RUN_W-1:0] good_run_nxt;
    logic [RUN_W-1:0] bad_run_nxt;
    logic             locked_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;

    always_comb begin
        good_inc     = (good_run == RUN_MAX) ? good_run : good_run + RUN_W'(1);
        bad_inc      = (bad_run == RUN_MAX) ? bad_run : bad_run + RUN_W'(1);
        good_run_nxt = good_run;
        bad_run_nxt  = bad_run;
        locked_nxt   = locked;
        err_cnt_nxt  = err_cnt;

        if (link_loss) begin
            good_run_nxt = '0;
            bad_run_nxt  = '0;
            locked_nxt   = 1'b0;
        end else if (eval_vld) begin
            if (eval_good) begin
                good_run_nxt = good_inc;
                bad_run_nxt  = '0;
                if (good_inc >= LOCK_TH) begin
                    locked_nxt = 1'b1;
                end
            end else begin
                bad_run_nxt  = bad_inc;
                good_run_nxt = '0;
                if (bad_inc >= UNLOCK_TH) begin
                    locked_nxt = 1'b0;
                end
                if (err_cnt != ERR_MAX) begin
                    err_cnt_nxt = err_cnt + ERR_W'(1);
                end
            end
        end

        // A clear in the same cycle as a bad verdict swallows that error.
        if (clr_err) begin
            err_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_run <= '0;
            bad_run  <= '0;
            locked   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            good_run <= good_run_nxt;
            bad_run  <= bad_run_nxt;
            locked   <= locked_nxt;
            err_cnt  <= err_cnt_nxt;
        end
    end

endmodule

// File: rtl/fem_cmd_deser.sv
// Serial command deserializer: hunts sync, checks frame, emits one-cycle FEM command pulses.
// Pulse rises two edges after the last stop bit lands in rx_q; no backpressure, pulses are fire-and-forget.
module fem_cmd_deser
    import fem_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = DEF_SYNC_WORD,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 2
) (
    input  logic       HS_CLK,
    input  logic       RST_N,
    input  logic       RX_DAT,
    input  logic       SIG_DET,
    input  logic       CTRL_FIBER_DET,
    input  logic       CLR_ERR,
    output logic       FEM_L1A,
    output logic       FEM_L1A_MATCH,
    output logic       FEM_RESYNC,
    output logic       FEM_INJPLS,
    output logic       FEM_EXTPLS,
    output logic       LOCKED,
    output logic [7:0] ERR_CNT
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PAYLOAD_W - 1);

    deser_state_t          state;
    deser_state_t          state_nxt;
    logic                  rx_q;
    logic [SYNC_W-1:0]     window;
    logic [SYNC_W-1:0]     shift_win;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [CMD_W-1:0]      pls_q;
    logic [CMD_W-1:0]      pls_nxt;
    logic                  link_loss;
    logic                  eval_vld;
    logic                  eval_good;
    payload_t              pl;

    assign link_loss = !SIG_DET || !CTRL_FIBER_DET;
    assign shift_win = {window[SYNC_W-2:0], rx_q};
    // After PAYLOAD the window holds exactly the eight payload bits.
    assign pl        = payload_t'(window);

    always_comb begin
        state_nxt = state;
        eval_vld  = 1'b0;
        eval_good = 1'b0;
        pls_nxt   = '0;

        case (state)
            HUNT: begin
                if (shift_win == SYNC_WORD) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = HUNT;
                eval_vld  = 1'b1;
                eval_good = frame_good(pl);
                // LOCKED here is the pre-update value, so the locking frame itself stays silent.
                if (eval_good && LOCKED) begin
                    pls_nxt = pl.cmd;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase

        if (link_loss) begin
            state_nxt = HUNT;
            eval_vld  = 1'b0;
            eval_good = 1'b0;
            pls_nxt   = '0;
        end
    end

    always_ff @(posedge HS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge HS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_q    <= 1'b0;
            window  <= '0;
            bit_cnt <= '0;
            pls_q   <= '0;
        end else begin
            rx_q  <= RX_DAT;
            pls_q <= pls_nxt;

            if (link_loss || state == EVAL) begin
                window <= '0;
            end else begin
                window <= shift_win;
            end

            if (!link_loss && state == PAYLOAD) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    fem_lock_mon #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_mon (
        .clk       (HS_CLK),
        .rst_n     (RST_N),
        .eval_vld  (eval_vld),
        .eval_good (eval_good),
        .link_loss (link_loss),
        .clr_err   (CLR_ERR),
        .locked    (LOCKED),
        .err_cnt   (ERR_CNT)
    );

    assign FEM_L1A       = pls_q[CMD_L1A];
    assign FEM_L1A_MATCH = pls_q[CMD_L1A_MATCH];
    assign FEM_RESYNC    = pls_q[CMD_RESYNC];
    assign FEM_INJPLS    = pls_q[CMD_INJPLS];
    assign FEM_EXTPLS    = pls_q[CMD_EXTPLS];

endmodule

// File: tb/tb_fem_cmd_deser.sv
// Bench for fem_cmd_deser: directed frame table, link-loss/saturation/reset sequences, random frames in idle noise.
module tb_fem_cmd_deser;

    localparam logic [7:0] SYNC     = 8'hB8;
    localparam int         LOCK_N   = 4;
    localparam int         UNLOCK_N = 2;

    logic       HS_CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX_DAT = 1'b0;
    logic       SIG_DET = 1'b1;
    logic       CTRL_FIBER_DET = 1'b1;
    logic       CLR_ERR = 1'b0;
    logic       FEM_L1A, FEM_L1A_MATCH, FEM_RESYNC, FEM_INJPLS, FEM_EXTPLS;
    logic       LOCKED;
    logic [7:0] ERR_CNT;
    logic [4:0] pls;

    fem_cmd_deser #(
        .SYNC_WORD  (SYNC),
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N)
    ) dut (
        .HS_CLK         (HS_CLK),
        .RST_N          (RST_N),
        .RX_DAT         (RX_DAT),
        .SIG_DET        (SIG_DET),
        .CTRL_FIBER_DET (CTRL_FIBER_DET),
        .CLR_ERR        (CLR_ERR),
        .FEM_L1A        (FEM_L1A),
        .FEM_L1A_MATCH  (FEM_L1A_MATCH),
        .FEM_RESYNC     (FEM_RESYNC),
        .FEM_INJPLS     (FEM_INJPLS),
        .FEM_EXTPLS     (FEM_EXTPLS),
        .LOCKED         (LOCKED),
        .ERR_CNT        (ERR_CNT)
    );

    assign pls = {FEM_L1A, FEM_L1A_MATCH, FEM_RESYNC, FEM_INJPLS, FEM_EXTPLS};

    always #5 HS_CLK = ~HS_CLK;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int n_pulse = 0;
    int exp_pulse = 0;

    // Output history indexed by the number of rising edges seen so far.
    logic [4:0] pls_h [int];
    logic       lk_h  [int];
    logic [7:0] err_h [int];

    always @(posedge HS_CLK) cyc = cyc + 1;

    always @(negedge HS_CLK) begin
        pls_h[cyc] = pls;
        lk_h[cyc]  = LOCKED;
        err_h[cyc] = ERR_CNT;
        if (pls != 5'd0) n_pulse = n_pulse + 1;
    end

    typedef struct {
        logic [4:0] cmd;
        logic       p;
        logic [1:0] stop;
        logic [4:0] e_pls;
        logic       e_lk;
        logic [7:0] e_err;
    } vec_t;

    typedef struct {
        int         k;
        logic [4:0] pls;
        logic       lk;
        logic [7:0] err;
        string      tag;
    } exp_t;

    exp_t expq[$];

    int m_good = 0;
    int m_bad = 0;
    int m_err = 0;
    bit m_lock = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HS_CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX_DAT = b;
        tick();
    endtask

    function automatic bit is_good(input logic [4:0] cmd, input logic p, input logic [1:0] stop);
        return ($countones({cmd, p}) % 2 == 0) && (stop == 2'b00) && !(cmd[3] && !cmd[4]);
    endfunction

    // Reference: per-frame verdict and link state from the frame rules.
    task automatic model_frame(input logic [4:0] cmd, input logic p, input logic [1:0] stop,
                               output logic [4:0] out_pls);
        bit g;
        g = is_good(cmd, p, stop);
        out_pls = (g && m_lock) ? cmd : 5'd0;
        if (g) begin
            m_bad  = 0;
            m_good = (m_good < 15) ? m_good + 1 : 15;
            if (m_good >= LOCK_N) m_lock = 1'b1;
        end else begin
            m_good = 0;
            m_bad  = (m_bad < 15) ? m_bad + 1 : 15;
            m_err  = (m_err < 255) ? m_err + 1 : 255;
            if (m_bad >= UNLOCK_N) m_lock = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_good = 0;
        m_bad  = 0;
        m_err  = 0;
        m_lock = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] cmd, input logic p, input logic [1:0] stop, output int k);
        logic [15:0] f;
        f = {SYNC, cmd, p, stop};
        for (int i = 15; i >= 0; i--) drive_bit(f[i]);
        k = cyc;
    endtask

    task automatic frame_chk(input logic [4:0] cmd, input logic p, input logic [1:0] stop, input string tag);
        int k;
        logic [4:0] mp;
        exp_t e;
        send_frame(cmd, p, stop, k);
        model_frame(cmd, p, stop, mp);
        e.k = k; e.pls = mp; e.lk = m_lock; e.err = 8'(m_err); e.tag = tag;
        expq.push_back(e);
        if (mp != 5'd0) exp_pulse = exp_pulse + 1;
        drive_bit(1'b0);
    endtask

    task automatic verify();
        repeat (4) drive_bit(1'b0);
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check($sformatf("%s_pls", e.tag), pls_h[e.k + 2], e.pls);
            check($sformatf("%s_lock", e.tag), lk_h[e.k + 2], e.lk);
            check($sformatf("%s_err", e.tag), err_h[e.k + 2], e.err);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [14];
        int   k_lock;

        vecs[0]  = '{5'b00100, 1'b1, 2'b00, 5'b00000, 1'b0, 8'd0};
        vecs[1]  = '{5'b00100, 1'b1, 2'b00, 5'b00000, 1'b0, 8'd0};
        vecs[2]  = '{5'b00100, 1'b1, 2'b00, 5'b00000, 1'b0, 8'd0};
        vecs[3]  = '{5'b00100, 1'b1, 2'b00, 5'b00000, 1'b1, 8'd0};
        vecs[4]  = '{5'b00100, 1'b1, 2'b00, 5'b00100, 1'b1, 8'd0};
        vecs[5]  = '{5'b11000, 1'b0, 2'b00, 5'b11000, 1'b1, 8'd0};
        vecs[6]  = '{5'b01000, 1'b1, 2'b00, 5'b00000, 1'b1, 8'd1};
        vecs[7]  = '{5'b10000, 1'b1, 2'b00, 5'b10000, 1'b1, 8'd1};
        vecs[8]  = '{5'b00001, 1'b0, 2'b00, 5'b00000, 1'b1, 8'd2};
        vecs[9]  = '{5'b00010, 1'b0, 2'b00, 5'b00000, 1'b0, 8'd3};
        vecs[10] = '{5'b00100, 1'b1, 2'b00, 5'b00000, 1'b0, 8'd3};
        vecs[11] = '{5'b00100, 1'b1, 2'b01, 5'b00000, 1'b0, 8'd4};
        vecs[12] = '{5'b11111, 1'b1, 2'b00, 5'b00000, 1'b0, 8'd4};
        vecs[13] = '{5'b00011, 1'b0, 2'b10, 5'b00000, 1'b0, 8'd5};

        // Reset state.
        repeat (3) tick();
        check("rst_pls", pls, 0);
        check("rst_lock", LOCKED, 0);
        check("rst_err", ERR_CNT, 0);
        RST_N = 1'b1;
        repeat (3) drive_bit(1'b0);

        // Directed table, one idle bit between frames.
        k_lock = 0;
        for (int i = 0; i < 14; i++) begin
            int k;
            logic [4:0] mp;
            exp_t e;
            send_frame(vecs[i].cmd, vecs[i].p, vecs[i].stop, k);
            model_frame(vecs[i].cmd, vecs[i].p, vecs[i].stop, mp);
            e.k = k; e.pls = vecs[i].e_pls; e.lk = vecs[i].e_lk; e.err = vecs[i].e_err;
            e.tag = $sformatf("tab%0d", i);
            expq.push_back(e);
            if (vecs[i].e_pls != 5'd0) exp_pulse = exp_pulse + 1;
            if (i == 3) k_lock = k;
            drive_bit(1'b0);
        end
        verify();
        check("lock_before_4th_eval", lk_h[k_lock + 1], 0);

        // Link loss for one cycle mid-payload while locked.
        for (int i = 0; i < 4; i++) frame_chk(5'b00100, 1'b1, 2'b00, $sformatf("relock%0d", i));
        frame_chk(5'b00001, 1'b1, 2'b00, "relock_pulse");
        verify();
        begin
            logic [15:0] f;
            f = {SYNC, 5'b00100, 1'b1, 2'b00};
            for (int i = 15; i >= 5; i--) drive_bit(f[i]);
            SIG_DET = 1'b0;
            drive_bit(f[4]);
            SIG_DET = 1'b1;
            for (int i = 3; i >= 0; i--) drive_bit(f[i]);
            repeat (4) drive_bit(1'b0);
        end
        m_good = 0; m_bad = 0; m_lock = 1'b0;
        check("sigdet_lock", LOCKED, 0);
        check("sigdet_err", ERR_CNT, 8'(m_err));

        // Fiber absent for a whole bad frame: nothing is evaluated.
        CTRL_FIBER_DET = 1'b0;
        begin
            int k;
            send_frame(5'b00000, 1'b0, 2'b11, k);
        end
        repeat (4) drive_bit(1'b0);
        CTRL_FIBER_DET = 1'b1;
        check("fiber_err", ERR_CNT, 8'(m_err));
        check("fiber_lock", LOCKED, 0);
        for (int i = 0; i < 4; i++) frame_chk(5'b00100, 1'b1, 2'b00, $sformatf("recov%0d", i));
        frame_chk(5'b11000, 1'b0, 2'b00, "recov_pulse");
        verify();

        // Error counter saturation, then clear racing a bad verdict.
        for (int i = 0; i < 300; i++) frame_chk(5'b00000, 1'b0, 2'b11, $sformatf("sat%0d", i));
        verify();
        check("err_sat", ERR_CNT, 255);
        begin
            int k;
            logic [4:0] mp;
            send_frame(5'b00000, 1'b0, 2'b11, k);
            model_frame(5'b00000, 1'b0, 2'b11, mp);
            drive_bit(1'b0);
            CLR_ERR = 1'b1;
            drive_bit(1'b0);
            CLR_ERR = 1'b0;
            m_err = 0;
            check("clr_same_eval", ERR_CNT, 0);
        end

        // Asynchronous reset while locked, with a pulse high and a new frame starting.
        frame_chk(5'b00000, 1'b1, 2'b00, "pre_rst_bad");
        for (int i = 0; i < 4; i++) frame_chk(5'b00100, 1'b1, 2'b00, $sformatf("pre_rst%0d", i));
        verify();
        begin
            int k;
            send_frame(5'b10000, 1'b1, 2'b00, k);
            drive_bit(1'b0);
            drive_bit(1'b1);
            check("pre_rst_pulse", pls, 5'b10000);
            RST_N = 1'b0;
            #2;
            check("rst_async_pls", pls, 0);
            check("rst_async_lock", LOCKED, 0);
            check("rst_async_err", ERR_CNT, 0);
            RX_DAT = 1'b0;
            tick();
            tick();
            RST_N = 1'b1;
            model_reset();
        end

        // Random frames embedded in random idle noise.
        for (int r = 0; r < 60; r++) begin
            logic [4:0]  cmd;
            logic        p;
            logic [1:0]  stop;
            int          sel;
            int          n;
            logic [15:0] idle;
            bit          hit;
            n = $urandom_range(0, 12);
            do begin
                idle = 16'($urandom);
                hit = 1'b0;
                for (int j = 0; j + 8 <= n; j++) if (idle[j +: 8] == SYNC) hit = 1'b1;
            end while (hit);
            for (int j = n - 1; j >= 0; j--) drive_bit(idle[j]);

            sel  = $urandom_range(0, 7);
            cmd  = 5'($urandom);
            stop = 2'b00;
            if (cmd[3]) cmd[4] = 1'b1;
            p = ^cmd;
            if (sel == 5) stop = 2'($urandom_range(1, 3));
            else if (sel == 6) p = ~p;
            else if (sel == 7) begin
                cmd[4] = 1'b0;
                cmd[3] = 1'b1;
                p = ^cmd;
            end
            frame_chk(cmd, p, stop, $sformatf("rnd%0d", r));
        end
        verify();

        check("pulse_count", n_pulse, exp_pulse);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
